// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Sequential radix-2 restoring divider for RV32M div/divu/rem/remu.
//               One quotient bit per cycle, MSB first. Divide-by-zero and
//               signed overflow take a single-cycle bypass path.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic [2:0]       div_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_done,
  output logic             div_stall
);

  localparam int             C_CNT_W   = $clog2(WIDTH);
  localparam logic [C_CNT_W-1:0] C_LAST_CNT = C_CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   C_INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_prem;      // partial remainder (always < divisor)
  logic [WIDTH-1:0]     r_dvd;       // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0]     r_dsr;       // divisor magnitude
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [WIDTH-1:0]     r_quotient;
  logic [WIDTH-1:0]     r_remainder;
  logic                 r_done;

  // Operation decode: bit 0 of the funct3 selects unsigned variants
  logic                 w_signed;
  logic                 w_div_zero;
  logic                 w_overflow;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_last;

  // One restoring step on the 33-bit partial remainder
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_sub;
  logic                 w_qbit;
  logic [WIDTH-1:0]     w_prem_nx;
  logic [WIDTH-1:0]     w_quo_nx;
  logic [WIDTH-1:0]     w_q_fix;
  logic [WIDTH-1:0]     w_r_fix;

  assign w_signed   = ~div_op[0];
  assign w_div_zero = (divisor == '0);
  assign w_overflow = w_signed && (dividend == C_INT_MIN) && (divisor == '1);
  assign w_a_mag    = (w_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_b_mag    = (w_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign w_last     = (r_cnt == C_LAST_CNT);

  assign w_shift    = {r_prem, r_dvd[WIDTH-1]};
  assign w_sub      = w_shift - {1'b0, r_dsr};
  assign w_qbit     = ~w_sub[WIDTH];
  assign w_prem_nx  = w_qbit ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nx   = {r_dvd[WIDTH-2:0], w_qbit};
  assign w_q_fix    = r_neg_q ? -w_quo_nx  : w_quo_nx;
  assign w_r_fix    = r_neg_r ? -w_prem_nx : w_prem_nx;

  assign quotient   = r_quotient;
  assign remainder  = r_remainder;
  assign div_done   = r_done;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and combinational stall towards the pipeline
  always_comb begin
    w_next    = r_state;
    div_stall = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (div_start) begin
          div_stall = 1'b1;
          w_next    = (w_div_zero || w_overflow) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        div_stall = 1'b1;
        if (w_last) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Operand capture, iterative datapath and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_prem      <= '0;
      r_dvd       <= '0;
      r_dsr       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_done      <= 1'b0;
    end else begin
      // DONE always lasts one cycle, so this yields a single-cycle pulse
      r_done <= (w_next == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (div_start) begin
            if (w_div_zero) begin
              r_quotient  <= '1;
              r_remainder <= dividend;
            end else if (w_overflow) begin
              r_quotient  <= C_INT_MIN;
              r_remainder <= '0;
            end else begin
              r_cnt   <= '0;
              r_prem  <= '0;
              r_dvd   <= w_a_mag;
              r_dsr   <= w_b_mag;
              r_neg_q <= w_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              r_neg_r <= w_signed && dividend[WIDTH-1];
            end
          end
        end
        ST_CALC: begin
          r_cnt  <= r_cnt + 1'b1;
          r_prem <= w_prem_nx;
          r_dvd  <= w_quo_nx;
          if (w_last) begin
            r_cnt       <= '0;
            r_quotient  <= w_q_fix;
            r_remainder <= w_r_fix;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider: directed corner cases,
//               randomized operations against an arithmetic reference model,
//               reset abort, ignored requests and back-to-back issue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start;
  logic [2:0]  div_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_done;
  logic        div_stall;

  int n_cmp = 0;
  int n_err = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .div_start (div_start),
    .div_op    (div_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .div_done  (div_done),
    .div_stall (div_stall)
  );

  always #5 clk = ~clk;

  // Architectural RV32M division semantics
  function automatic void ref_model(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] q,
                                    output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFFFFFF;
      r = a;
    end else if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      q = 32'h80000000;
      r = 32'd0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issue one operation from IDLE; report results, latency in edges after
  // capture, whether stall behaved, and whether done was a single pulse.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r,
                        output int lat, output bit stall_ok, output bit pulse_ok);
    @(negedge clk);
    div_op = op; dividend = a; divisor = b; div_start = 1'b1;
    #1;
    stall_ok = (div_stall === 1'b1);
    @(posedge clk); #1;
    div_start = 1'b0;
    div_op    = 3'($urandom);
    dividend  = $urandom;
    divisor   = $urandom;
    lat = 0;
    while (div_done !== 1'b1 && lat < 40) begin
      if (div_stall !== 1'b1) stall_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    q = quotient;
    r = remainder;
    if (div_stall !== 1'b0) stall_ok = 1'b0;
    @(posedge clk); #1;
    pulse_ok = (div_done === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0; div_start = 1'b0; div_op = OP_DIV; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (quotient !== 32'd0) begin n_err++; $display("FAIL reset_q: got %h want %h", quotient, 32'd0); end
    n_cmp++; if (remainder !== 32'd0) begin n_err++; $display("FAIL reset_r: got %h want %h", remainder, 32'd0); end
    n_cmp++; if (div_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", div_done); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (div_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", div_stall); end
  endtask

  task automatic test_basic();
    logic [31:0] q, r; int lat; bit s_ok, p_ok;
    run_op(OP_DIV, 32'd15, 32'd4, q, r, lat, s_ok, p_ok);
    n_cmp++; if (q !== 32'd3) begin n_err++; $display("FAIL basic_q: got %h want %h", q, 32'd3); end
    n_cmp++; if (r !== 32'd3) begin n_err++; $display("FAIL basic_r: got %h want %h", r, 32'd3); end
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL basic_latency: got %0d want 32", lat); end
    n_cmp++; if (!s_ok) begin n_err++; $display("FAIL basic_stall: got bad want high in CALC/low in DONE"); end
    n_cmp++; if (!p_ok) begin n_err++; $display("FAIL basic_pulse: got done>1 cycle want 1 cycle"); end
  endtask

  task automatic test_signed();
    logic [31:0] q, r; int lat; bit s_ok, p_ok;
    run_op(OP_REM, 32'hFFFFFFEE, 32'd7, q, r, lat, s_ok, p_ok);
    n_cmp++; if (r !== 32'hFFFFFFFC) begin n_err++; $display("FAIL rem_m18_7: got %h want %h", r, 32'hFFFFFFFC); end
    run_op(OP_DIV, 32'hFFFFFFEE, 32'd7, q, r, lat, s_ok, p_ok);
    n_cmp++; if (q !== 32'hFFFFFFFE) begin n_err++; $display("FAIL div_m18_7: got %h want %h", q, 32'hFFFFFFFE); end
    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, q, r, lat, s_ok, p_ok);
    n_cmp++; if (q !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_7_m2_q: got %h want %h", q, 32'hFFFFFFFD); end
    n_cmp++; if (r !== 32'd1) begin n_err++; $display("FAIL div_7_m2_r: got %h want %h", r, 32'd1); end
  endtask

  task automatic test_unsigned();
    logic [31:0] q, r; int lat; bit s_ok, p_ok;
    run_op(OP_DIVU, 32'hFFFFFFFF, 32'd1, q, r, lat, s_ok, p_ok);
    n_cmp++; if (q !== 32'hFFFFFFFF) begin n_err++; $display("FAIL divu_max_1: got %h want %h", q, 32'hFFFFFFFF); end
    run_op(OP_DIV, 32'hFFFFFFFF, 32'd1, q, r, lat, s_ok, p_ok);
    n_cmp++; if (q !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_m1_1: got %h want %h", q, 32'hFFFFFFFF); end
    run_op(OP_REMU, 32'hFFFFFFFF, 32'd16, q, r, lat, s_ok, p_ok);
    n_cmp++; if (r !== 32'd15) begin n_err++; $display("FAIL remu_max_16: got %h want %h", r, 32'd15); end
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r; int lat; bit s_ok, p_ok;
    for (int op = 4; op < 8; op++) begin
      run_op(3'(op), 32'd5, 32'd0, q, r, lat, s_ok, p_ok);
      n_cmp++; if (q !== 32'hFFFFFFFF) begin n_err++; $display("FAIL dz_q op%0d: got %h want %h", op, q, 32'hFFFFFFFF); end
      n_cmp++; if (r !== 32'd5) begin n_err++; $display("FAIL dz_r op%0d: got %h want %h", op, r, 32'd5); end
      n_cmp++; if (lat !== 0) begin n_err++; $display("FAIL dz_latency op%0d: got %0d want 0", op, lat); end
      n_cmp++; if (!p_ok) begin n_err++; $display("FAIL dz_pulse op%0d: got done>1 cycle want 1 cycle", op); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] q, r; int lat; bit s_ok, p_ok;
    logic [2:0] ops [2];
    ops[0] = OP_DIV; ops[1] = OP_REM;
    for (int i = 0; i < 2; i++) begin
      run_op(ops[i], 32'h80000000, 32'hFFFFFFFF, q, r, lat, s_ok, p_ok);
      n_cmp++; if (q !== 32'h80000000) begin n_err++; $display("FAIL ovf_q op%0d: got %h want %h", ops[i], q, 32'h80000000); end
      n_cmp++; if (r !== 32'd0) begin n_err++; $display("FAIL ovf_r op%0d: got %h want %h", ops[i], r, 32'd0); end
      n_cmp++; if (lat !== 0) begin n_err++; $display("FAIL ovf_latency op%0d: got %0d want 0", ops[i], lat); end
    end
  endtask

  task automatic test_random();
    logic [31:0] q, r, eq, er, a, b; int lat, elat, sel; bit s_ok, p_ok; logic [2:0] op;
    for (int i = 0; i < 30; i++) begin
      op  = 3'(4 + $urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      a = $urandom; b = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (sel < 5) begin
        b = 32'($urandom_range(1, 15));
        if (sel == 4) b = -b;
      end
      ref_model(op, a, b, eq, er);
      elat = (b == 32'd0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 0 : 32;
      run_op(op, a, b, q, r, lat, s_ok, p_ok);
      if (op[1]) begin
        n_cmp++; if (r !== er) begin n_err++; $display("FAIL rand_r op%0d %h/%h: got %h want %h", op, a, b, r, er); end
      end else begin
        n_cmp++; if (q !== eq) begin n_err++; $display("FAIL rand_q op%0d %h/%h: got %h want %h", op, a, b, q, eq); end
      end
      n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL rand_latency op%0d %h/%h: got %0d want %0d", op, a, b, lat, elat); end
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [31:0] q, r; int lat; bit s_ok, p_ok, saw;
    run_op(OP_DIV, 32'd100, 32'd7, q, r, lat, s_ok, p_ok);
    @(negedge clk);
    div_op = OP_DIVU; dividend = 32'd1000; divisor = 32'd3; div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_cmp++; if (quotient !== 32'd0) begin n_err++; $display("FAIL abort_q: got %h want %h", quotient, 32'd0); end
    n_cmp++; if (remainder !== 32'd0) begin n_err++; $display("FAIL abort_r: got %h want %h", remainder, 32'd0); end
    n_cmp++; if (div_stall !== 1'b0) begin n_err++; $display("FAIL abort_stall: got %b want 0", div_stall); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (div_done === 1'b1) saw = 1'b1;
    end
    n_cmp++; if (saw) begin n_err++; $display("FAIL abort_done: got done pulse want none"); end
    run_op(OP_DIVU, 32'd1000, 32'd3, q, r, lat, s_ok, p_ok);
    n_cmp++; if (q !== 32'd333 || r !== 32'd1) begin n_err++; $display("FAIL reissue: got %0d r%0d want 333 r1", q, r); end
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL reissue_latency: got %0d want 32", lat); end
  endtask

  task automatic test_ignore_start();
    int lat; bit saw;
    @(negedge clk);
    div_op = OP_DIV; dividend = 32'd200; divisor = 32'd6; div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0;
    lat = 0;
    while (div_done !== 1'b1 && lat < 40) begin
      if (lat == 10) begin
        div_start = 1'b1; div_op = OP_REM; dividend = 32'd9; divisor = 32'd0;
      end else begin
        div_start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    div_start = 1'b0;
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL ignore_latency: got %0d want 32", lat); end
    n_cmp++; if (quotient !== 32'd33 || remainder !== 32'd2) begin n_err++; $display("FAIL ignore_result: got %0d r%0d want 33 r2", quotient, remainder); end
    saw = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (div_done === 1'b1) saw = 1'b1;
    end
    n_cmp++; if (saw) begin n_err++; $display("FAIL ignore_queued: got extra done want none"); end
    n_cmp++; if (quotient !== 32'd33) begin n_err++; $display("FAIL hold_q: got %h want %h", quotient, 32'd33); end
    n_cmp++; if (div_stall !== 1'b0) begin n_err++; $display("FAIL idle_stall: got %b want 0", div_stall); end
  endtask

  task automatic test_back_to_back();
    int lat, gap;
    @(negedge clk);
    div_op = OP_DIV; dividend = 32'd100; divisor = 32'd7; div_start = 1'b1;
    @(posedge clk); #1;
    dividend = 32'd100; divisor = 32'd9;
    lat = 0;
    while (div_done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL b2b_first_latency: got %0d want 32", lat); end
    n_cmp++; if (quotient !== 32'd14 || remainder !== 32'd2) begin n_err++; $display("FAIL b2b_first: got %0d r%0d want 14 r2", quotient, remainder); end
    n_cmp++; if (div_stall !== 1'b0) begin n_err++; $display("FAIL b2b_done_stall: got %b want 0", div_stall); end
    @(posedge clk); #1;
    n_cmp++; if (div_stall !== 1'b1) begin n_err++; $display("FAIL b2b_idle_req_stall: got %b want 1", div_stall); end
    @(posedge clk); #1;
    div_start = 1'b0;
    gap = 2;
    while (div_done !== 1'b1 && gap < 80) begin
      @(posedge clk); #1;
      gap++;
    end
    n_cmp++; if (gap !== 34) begin n_err++; $display("FAIL b2b_gap: got %0d want 34", gap); end
    n_cmp++; if (quotient !== 32'd11 || remainder !== 32'd1) begin n_err++; $display("FAIL b2b_second: got %0d r%0d want 11 r1", quotient, remainder); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_unsigned();
    test_div_zero();
    test_overflow();
    test_random();
    test_reset_mid_calc();
    test_ignore_start();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset; rst=0 resets.
REQ-005 div_start  input  1  request; sampled only in IDLE.
REQ-006 div_op  input  3  mult_funct3_t operation:
  - div=3'b100
  - divu=3'b101
  - rem=3'b110
  - remu=3'b111
REQ-007 dividend  input  32  operand A; signed for div/rem, unsigned for divu/remu.
REQ-008 divisor  input  32  operand B; same signedness rule as dividend.
REQ-009 quotient  output  32  registered quotient result.
REQ-010 remainder  output  32  registered remainder result.
REQ-011 div_done  output  1  registered one-cycle pulse; result valid.
REQ-012 div_stall  output  1  combinational busy indication to the issuing pipeline.

Function
REQ-013 FSM states: IDLE, CALC, DONE.
REQ-014 Capture edge: IDLE with div_start=1 at a rising edge latches dividend, divisor and div_op; inputs are don't-care after that edge.
REQ-015 Special-case priority: divide-by-zero is checked first, then signed overflow, then the normal path.
REQ-016 Divide-by-zero (divisor==0, any op): capture edge goes IDLE->DONE; quotient=32'hFFFFFFFF, remainder=dividend.
REQ-017 Signed overflow (div/rem, dividend=32'h80000000, divisor=32'hFFFFFFFF): capture edge goes IDLE->DONE; quotient=32'h80000000, remainder=0.
REQ-018 Normal path: capture edge goes IDLE->CALC with iteration counter=0.
  - Signed ops: operands converted to magnitudes.
  - Unsigned ops: operands used as-is.
REQ-019 CALC datapath: restoring radix-2, one quotient bit per cycle, MSB first.
  - 33-bit partial remainder.
  - 32 CALC cycles total.
  - The 32nd CALC edge writes quotient/remainder and goes CALC->DONE.
REQ-020 Sign fix (signed ops only):
  - quotient negated when operand signs differ;
  - remainder negated when dividend is negative;
  - remainder sign always equals dividend sign (or remainder is zero).
REQ-021 Outputs: quotient and remainder are both written for every op regardless of div_op; only the op-relevant field is architecturally checked.
REQ-022 DONE: div_done=1 for exactly one cycle; next edge goes DONE->IDLE unconditionally.
REQ-023 Latency: div_done=1 in the cycle immediately following the k-th rising edge after the capture edge, where the capture edge itself is edge 0.
  - Normal path: k=32, i.e. 33 edges including capture.
  - Special cases (REQ-016/017): k=0, i.e. visible right after the capture edge.
REQ-024 div_stall=1 when (state==IDLE and div_start==1) or state==CALC; div_stall=0 in DONE and in idle without a request.
REQ-025 div_start asserted in CALC or DONE is ignored; no queuing.
  - A request held across DONE is captured on the first IDLE edge.
REQ-026 Back-to-back: a new capture may occur on the edge immediately after DONE.
REQ-027 Result hold: quotient/remainder hold their last value until the next result write; div_done low outside DONE.
REQ-028 div_op changes after the capture edge do not affect the in-flight operation.

Reset
REQ-029 rst=0 forces immediately, without waiting for clk:
  - state=IDLE;
  - counter=0;
  - quotient=0, remainder=0;
  - div_done=0.
REQ-030 Reset asserted mid-CALC aborts the operation; no div_done is produced for it.
  - The first request after rst deasserts behaves as a fresh capture.
REQ-031 After reset, with div_start=0, div_stall=0.

Verification
REQ-032 Basic latency: div 15/4 -> quotient=3, remainder=3; div_done exactly 33 edges after start is sampled (counting the capture edge); div_stall high throughout CALC.
REQ-033 Signed remainder: rem -18/7 -> remainder=-4 (32'hFFFFFFFC); div -18/7 -> quotient=-2; div 7/-2 -> quotient=-3, remainder=1.
REQ-034 Unsigned vs signed: divu 32'hFFFFFFFF/1 -> quotient=32'hFFFFFFFF; div 32'hFFFFFFFF/1 -> quotient=32'hFFFFFFFF (=-1); remu 32'hFFFFFFFF/16 -> remainder=15.
REQ-035 Divide-by-zero: each op with dividend=5, divisor=0 -> quotient=32'hFFFFFFFF, remainder=5, div_done the cycle after the capture edge.
REQ-036 Overflow: div/rem 32'h80000000 / -1 -> quotient=32'h80000000, remainder=0, single-cycle path.
REQ-037 Reset and re-issue:
  - rst=0 at CALC cycle 10 -> no div_done, outputs=0.
  - div_start pulsed again mid-CALC -> ignored.
  - Back-to-back 100/7 then 100/9 -> 14/2 then 11/1.
